qkv_seq_ctrl: RTL and testbench

Sequencer for the binary Q/K/V projection engine. Pulls a sequence of SEQ_LEN binary tokens from the upstream token buffer, issues each token to the engine once per selected weight block, and tags every engine result with block and token index. Results are buffered in a small credit-guarded FIFO for the attention stage. The controller sits between the token buffer and the downstream attention-score unit, and it owns `block_sel` sequencing and sequence-level `done`.

---
 rtl/qkv_pkg.sv | 53 +++++
 rtl/qkv_res_fifo.sv | 55 +++++
 rtl/qkv_seq_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_qkv_seq_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/qkv_pkg.sv
// Shared types and constants for the Q/K/V sequencer.
//   state_t   : sequencer FSM states
//   tag_t     : {blk, tok, last} carried beside the engine
//   res_t     : result FIFO entry {q, k, v, blk, tok, last}
//   clamp_blk_cnt : maps a raw block count onto the legal range 1..NUM_BLK_MAX
package qkv_pkg;

  localparam int DATA_W      = 16;
  localparam int SEQ_LEN     = 30;
  localparam int TI_W        = $clog2(SEQ_LEN);
  localparam int NUM_BLK_MAX = 3;
  localparam int BLK_W       = 2;
  localparam int ENG_LAT     = 1;
  localparam int FIFO_DEPTH  = 4;
  localparam int CRED_W      = $clog2(FIFO_DEPTH + 1);
  // Window after reset in which untagged engine results are silently dropped.
  localparam int GUARD_W     = $clog2(ENG_LAT + 2);

  localparam logic [TI_W-1:0]    TOK_LAST   = TI_W'(SEQ_LEN - 1);
  localparam logic [CRED_W-1:0]  CRED_MAX   = CRED_W'(FIFO_DEPTH);
  localparam logic [GUARD_W-1:0] GUARD_INIT = GUARD_W'(ENG_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [BLK_W-1:0] blk;
    logic [TI_W-1:0]  tok;
    logic             last;
  } tag_t;

  typedef struct packed {
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] k;
    logic [DATA_W-1:0] v;
    logic [BLK_W-1:0]  blk;
    logic [TI_W-1:0]   tok;
    logic              last;
  } res_t;

  localparam int RES_W = $bits(res_t);

  function automatic logic [BLK_W-1:0] clamp_blk_cnt(input logic [BLK_W-1:0] cnt);
    if (cnt == '0) return BLK_W'(1);
    if (cnt > BLK_W'(NUM_BLK_MAX)) return BLK_W'(NUM_BLK_MAX);
    return cnt;
  endfunction

endpackage

// File: rtl/qkv_res_fifo.sv
// Result FIFO, FIFO_DEPTH entries. The head entry is read straight out of the
// storage flops, so a push is visible on dout the cycle after it is written.
//   push/din  : write request and entry; ignored when full
//   pop       : read request; ignored when empty
//   dout      : head entry, stable until popped
//   full/empty: occupancy flags
module qkv_res_fifo
  import qkv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [RES_W-1:0] din,
  input  logic             pop,
  output logic [RES_W-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [RES_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/qkv_seq_ctrl.sv
// Q/K/V projection sequencer. Streams SEQ_LEN tokens per weight block into the
// engine, tags each result with {blk, tok, last} and buffers it for the
// attention stage behind a credit counter that never over-commits the FIFO.
//   start/cfg_blk_cnt        : sequence launch and block count (IDLE only)
//   tok_*                    : upstream token handshake (tokens replayed per block)
//   eng_data_in*/block_sel   : registered engine issue port
//   eng_query/key/value/out_valid : engine results, ENG_LAT after issue
//   res_*                    : downstream result handshake
//   busy/done/err            : status; err is sticky until the next start
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing tokens while credits remain
// DRAIN | last token issued, waiting for every result to be popped
// DONE  | one-cycle completion pulse
module qkv_seq_ctrl
  import qkv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        cfg_blk_cnt,
  input  logic [DATA_W-1:0] tok_data,
  input  logic              tok_valid,
  output logic              tok_ready,
  output logic [DATA_W-1:0] eng_data_in,
  output logic              eng_data_in_valid,
  output logic [1:0]        eng_block_sel,
  input  logic [DATA_W-1:0] eng_query,
  input  logic [DATA_W-1:0] eng_key,
  input  logic [DATA_W-1:0] eng_value,
  input  logic              eng_data_out_valid,
  output logic [DATA_W-1:0] res_q,
  output logic [DATA_W-1:0] res_k,
  output logic [DATA_W-1:0] res_v,
  output logic [1:0]        res_blk,
  output logic [TI_W-1:0]   res_tok,
  output logic              res_last,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t              state, state_nxt;
  logic [TI_W-1:0]     tok_idx;
  logic [BLK_W-1:0]    blk_idx;
  logic [BLK_W-1:0]    blk_cnt;
  logic [CRED_W-1:0]   credit, credit_nxt;
  logic [GUARD_W-1:0]  guard;
  logic [TI_W-1:0]     eng_tok;
  logic                eng_last;
  logic                tag_vld [ENG_LAT];
  tag_t                tag     [ENG_LAT];
  logic                start_ok, issue, pop, seq_last;
  logic                tag_hit, push, err_set;
  logic                fifo_full, fifo_empty;
  res_t                fifo_din, fifo_dout;

  assign start_ok = (state == IDLE) && start;
  assign seq_last = (tok_idx == TOK_LAST) && (blk_idx == blk_cnt - BLK_W'(1));
  assign res_valid = !fifo_empty;

  always_comb begin
    state_nxt  = state;
    tok_ready  = 1'b0;
    busy       = (state != IDLE);
    done       = (state == DONE);
    if (state == RUN && credit != '0) tok_ready = 1'b1;
    issue      = tok_ready && tok_valid;
    pop        = res_valid && res_ready;
    credit_nxt = credit;
    if (issue && !pop)      credit_nxt = credit - CRED_W'(1);
    else if (pop && !issue) credit_nxt = credit + CRED_W'(1);
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (issue && seq_last) state_nxt = DRAIN;
      // Looking at next-cycle credit lets done follow the final pop directly.
      DRAIN:   if (credit_nxt == CRED_MAX) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      credit <= CRED_MAX;
    end else begin
      state  <= state_nxt;
      credit <= credit_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_idx <= '0;
      blk_idx <= '0;
      blk_cnt <= '0;
    end else if (start_ok) begin
      tok_idx <= '0;
      blk_idx <= '0;
      blk_cnt <= clamp_blk_cnt(cfg_blk_cnt);
    end else if (issue) begin
      if (tok_idx == TOK_LAST) begin
        tok_idx <= '0;
        blk_idx <= seq_last ? '0 : blk_idx + BLK_W'(1);
      end else begin
        tok_idx <= tok_idx + TI_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_data_in_valid <= 1'b0;
      eng_data_in       <= '0;
      eng_block_sel     <= '0;
      eng_tok           <= '0;
      eng_last          <= 1'b0;
    end else begin
      eng_data_in_valid <= issue;
      if (issue) begin
        eng_data_in   <= tok_data;
        eng_block_sel <= blk_idx;
        eng_tok       <= tok_idx;
        eng_last      <= seq_last;
      end
    end
  end

  // Tags ride ENG_LAT stages behind the issue register so they meet the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENG_LAT; i++) begin
        tag_vld[i] <= 1'b0;
        tag[i]     <= '0;
      end
    end else begin
      tag_vld[0]   <= eng_data_in_valid;
      tag[0].blk   <= eng_block_sel;
      tag[0].tok   <= eng_tok;
      tag[0].last  <= eng_last;
      for (int i = 1; i < ENG_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag[i]     <= tag[i-1];
      end
    end
  end

  assign tag_hit = tag_vld[ENG_LAT-1];
  assign push    = eng_data_out_valid && tag_hit && !fifo_full;
  // Untagged results inside the post-reset window belong to a killed sequence.
  assign err_set = eng_data_out_valid && (tag_hit ? fifo_full : (guard == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      guard <= GUARD_INIT;
      err   <= 1'b0;
    end else begin
      if (guard != '0) guard <= guard - GUARD_W'(1);
      if (start_ok)     err <= 1'b0;
      else if (err_set) err <= 1'b1;
    end
  end

  always_comb begin
    fifo_din      = '0;
    fifo_din.q    = eng_query;
    fifo_din.k    = eng_key;
    fifo_din.v    = eng_value;
    fifo_din.blk  = tag[ENG_LAT-1].blk;
    fifo_din.tok  = tag[ENG_LAT-1].tok;
    fifo_din.last = tag[ENG_LAT-1].last;
  end

  qkv_res_fifo u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign res_q    = fifo_dout.q;
  assign res_k    = fifo_dout.k;
  assign res_v    = fifo_dout.v;
  assign res_blk  = fifo_dout.blk;
  assign res_tok  = fifo_dout.tok;
  assign res_last = fifo_dout.last;

endmodule

// File: tb/tb_qkv_seq_ctrl.sv
// Bench for qkv_seq_ctrl: a behavioural one-cycle engine, a replaying token
// source, and scoreboards for engine issues and buffered results.
module tb_qkv_seq_ctrl;
  import qkv_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        cfg_blk_cnt = '0;
  logic [DATA_W-1:0] tok_data = '0;
  logic              tok_valid = 1'b0;
  logic              tok_ready;
  logic [DATA_W-1:0] eng_data_in;
  logic              eng_data_in_valid;
  logic [1:0]        eng_block_sel;
  logic [DATA_W-1:0] eng_query = '0;
  logic [DATA_W-1:0] eng_key = '0;
  logic [DATA_W-1:0] eng_value = '0;
  logic              eng_data_out_valid;
  logic [DATA_W-1:0] res_q, res_k, res_v;
  logic [1:0]        res_blk;
  logic [TI_W-1:0]   res_tok;
  logic              res_last, res_valid;
  logic              res_ready = 1'b0;
  logic              busy, done, err;

  logic eng_vld_r = 1'b0;
  logic spur = 1'b0;

  int checks = 0;
  int errors = 0;

  res_t sb [$];
  logic [BLK_W+DATA_W-1:0] iq [$];

  typedef struct {
    logic [1:0] cfg;
    int         nblk;
    int         stall;
    bit         poke;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  // Engine: fixed latency of one cycle, distinct function per output.
  always @(posedge clk) begin
    eng_vld_r <= eng_data_in_valid;
    eng_query <= eng_data_in ^ DATA_W'(eng_block_sel);
    eng_key   <= eng_data_in + DATA_W'(eng_block_sel) + DATA_W'(1);
    eng_value <= ~eng_data_in;
  end
  assign eng_data_out_valid = eng_vld_r | spur;

  qkv_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_blk_cnt(cfg_blk_cnt),
    .tok_data(tok_data), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .eng_data_in(eng_data_in), .eng_data_in_valid(eng_data_in_valid),
    .eng_block_sel(eng_block_sel), .eng_query(eng_query), .eng_key(eng_key),
    .eng_value(eng_value), .eng_data_out_valid(eng_data_out_valid),
    .res_q(res_q), .res_k(res_k), .res_v(res_v), .res_blk(res_blk),
    .res_tok(res_tok), .res_last(res_last), .res_valid(res_valid),
    .res_ready(res_ready), .busy(busy), .done(done), .err(err)
  );

  function automatic logic [DATA_W-1:0] tok_val(input int t);
    return DATA_W'(32'h1357 + t * 613);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_seq(input logic [1:0] cfg, input int nblk, input int stall,
                         input bit poke, input int abort_at,
                         output int n_res, output int n_done);
    int total, src, cyc, t, b;
    bit done_due, finished;
    logic [DATA_W-1:0] tv;
    res_t e;
    total = nblk * SEQ_LEN;
    src = 0; cyc = 0; done_due = 0; finished = 0; n_res = 0; n_done = 0;
    sb.delete();
    iq.delete();
    @(negedge clk);
    start = 1'b1; cfg_blk_cnt = cfg; tok_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("busy_after_start", busy, 1);
    chk("err_clear_on_start", err, 0);
    while (!finished && cyc < 4000) begin
      res_ready   = (cyc >= stall);
      tok_valid   = (src < total);
      tok_data    = tok_val(src % SEQ_LEN);
      start       = poke && (cyc == 5);
      cfg_blk_cnt = poke ? 2'd3 : cfg;
      #1;
      if (abort_at >= 0 && src == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("reset_outputs_zero",
            {tok_ready, eng_data_in, eng_data_in_valid, eng_block_sel, res_q, res_k,
             res_v, res_blk, res_tok, res_last, res_valid, busy, done, err}, 0);
        #1 rst_n = 1'b1;
        tok_valid = 1'b0;
        start = 1'b0;
        sb.delete();
        iq.delete();
        return;
      end
      if (stall > 0 && cyc == stall - 1) begin
        chk("bp_issue_count", src, 4);
        chk("bp_tok_ready", tok_ready, 0);
        chk("bp_err", err, 0);
      end
      if (eng_data_in_valid) begin
        if (iq.size() == 0) chk("issue_unexpected", iq.size(), 1);
        else chk("eng_issue", {eng_block_sel, eng_data_in}, iq.pop_front());
      end
      if (done) n_done++;
      if (done_due) begin
        chk("done_after_last_pop", done, 1);
        finished = 1;
      end
      if (tok_valid && tok_ready) begin
        t  = src % SEQ_LEN;
        b  = src / SEQ_LEN;
        tv = tok_val(t);
        e.q = tv ^ DATA_W'(b);
        e.k = tv + DATA_W'(b) + DATA_W'(1);
        e.v = ~tv;
        e.blk = BLK_W'(b);
        e.tok = TI_W'(t);
        e.last = (src == total - 1);
        sb.push_back(e);
        iq.push_back({BLK_W'(b), tv});
        src++;
      end
      if (res_valid && res_ready) begin
        if (sb.size() == 0) chk("result_unexpected", sb.size(), 1);
        else chk("result", {res_q, res_k, res_v, res_blk, res_tok, res_last}, sb.pop_front());
        n_res++;
        if (n_res == total) done_due = 1;
      end
      if (!finished) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("seq_finished", finished, 1);
    @(negedge clk);
    tok_valid = 1'b0;
    #1;
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    int n_res, n_done;
    vecs[0] = '{cfg: 2'd1, nblk: 1, stall: 0,  poke: 1'b0};
    vecs[1] = '{cfg: 2'd3, nblk: 3, stall: 0,  poke: 1'b0};
    vecs[2] = '{cfg: 2'd1, nblk: 1, stall: 20, poke: 1'b0};
    vecs[3] = '{cfg: 2'd0, nblk: 1, stall: 0,  poke: 1'b0};
    vecs[4] = '{cfg: 2'd1, nblk: 1, stall: 0,  poke: 1'b1};
    vecs[5] = '{cfg: 2'd2, nblk: 2, stall: 7,  poke: 1'b0};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state",
        {tok_ready, eng_data_in, eng_data_in_valid, eng_block_sel, res_q, res_k,
         res_v, res_blk, res_tok, res_last, res_valid, busy, done, err}, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_seq(vecs[i].cfg, vecs[i].nblk, vecs[i].stall, vecs[i].poke, -1, n_res, n_done);
      chk($sformatf("vec%0d_result_count", i), n_res, vecs[i].nblk * SEQ_LEN);
      chk($sformatf("vec%0d_done_pulses", i), n_done, 1);
      chk($sformatf("vec%0d_no_err", i), err, 0);
    end

    // Spurious engine strobe while idle.
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    #1;
    chk("spurious_sets_err", err, 1);
    chk("spurious_no_push", res_valid, 0);

    // Reset at token 12 of block 1, with an engine result still in flight.
    run_seq(2'd2, 2, 0, 1'b0, SEQ_LEN + 12, n_res, n_done);
    repeat (4) @(negedge clk);
    #1;
    chk("reset_inflight_no_err", err, 0);
    chk("reset_inflight_no_push", res_valid, 0);
    chk("reset_idle", busy, 0);

    run_seq(2'd1, 1, 0, 1'b0, -1, n_res, n_done);
    chk("post_reset_result_count", n_res, SEQ_LEN);
    chk("post_reset_done_pulses", n_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
